// File: rtl/lbp_param_if.sv
// rtl/lbp_param_if.sv - gray-memory read port and LBP result write port of lbp_param
interface lbp_param_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
);
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;

  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_param.sv
// rtl/lbp_param.sv - parametrised 3x3 LBP engine; LBP_BORDER_WRITE_EN adds a border-zeroing pre-pass
module lbp_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input logic         clk,
  input logic         reset,
  lbp_param_if.master io_bus
);
  localparam logic [ADDR_W-1:0] LP_W        = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LP_W2       = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] LP_COL_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] LP_ROW_LAST = ADDR_W'(IMG_H - 2);

  typedef enum logic [2:0] {S_IDLE, S_BORDER, S_LOAD, S_COL, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_row, r_col, r_base, r_row_base;
  logic [1:0]        r_kc, r_kr, r_dc, r_dr;
  logic              r_req_d, r_dlast;
  logic [PIX_W-1:0]  r_win [3][3];
  logic [PIX_W-1:0]  w_win_n [3][3];
  logic [PIX_W-1:0]  w_ctr;
  logic [1:0]        w_kc_n, w_kr_n;
  logic [ADDR_W-1:0] w_next;
  logic [7:0]        w_code;

  function automatic logic [ADDR_W-1:0] row_off(input logic [1:0] k);
    case (k)
      2'd0:    return '0;
      2'd1:    return LP_W;
      default: return LP_W2;
    endcase
  endfunction

  // Window is indexed [col][row]; w_win_n includes the word landing this edge so the code is ready for WRITE.
  always_comb begin
    w_win_n = r_win;
    if (r_req_d) w_win_n[r_dc][r_dr] = io_bus.gray_data;
    w_ctr  = w_win_n[1][1];
    w_code = {w_win_n[2][2] >= w_ctr, w_win_n[1][2] >= w_ctr, w_win_n[0][2] >= w_ctr,
              w_win_n[2][1] >= w_ctr, w_win_n[0][1] >= w_ctr,
              w_win_n[2][0] >= w_ctr, w_win_n[1][0] >= w_ctr, w_win_n[0][0] >= w_ctr};
    w_kr_n = (r_kr == 2'd2) ? 2'd0 : r_kr + 2'd1;
    w_kc_n = (r_kr == 2'd2) ? r_kc + 2'd1 : r_kc;
    w_next = r_base + row_off(w_kr_n) + ADDR_W'(w_kc_n);
  end

`ifdef LBP_BORDER_WRITE_EN
  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  logic [ADDR_W-1:0] r_bcol, r_brow, w_bcol_n, w_brow_n;
  logic              w_bord_n;

  always_comb begin
    w_bcol_n = (r_bcol == LP_W - 1'b1) ? '0 : r_bcol + 1'b1;
    w_brow_n = (r_bcol == LP_W - 1'b1) ? r_brow + 1'b1 : r_brow;
    w_bord_n = (w_brow_n == '0) || (w_brow_n == ADDR_W'(IMG_H - 1)) ||
               (w_bcol_n == '0) || (w_bcol_n == LP_W - 1'b1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      io_bus.gray_req   <= 1'b0;
      io_bus.gray_addr  <= '0;
      io_bus.lbp_valid  <= 1'b0;
      io_bus.lbp_addr   <= '0;
      io_bus.lbp_data   <= '0;
      io_bus.finish     <= 1'b0;
      r_row             <= '0;
      r_col             <= '0;
      r_base            <= '0;
      r_row_base        <= '0;
      r_kc              <= '0;
      r_kr              <= '0;
      r_dc              <= '0;
      r_dr              <= '0;
      r_req_d           <= 1'b0;
      r_dlast           <= 1'b0;
`ifdef LBP_BORDER_WRITE_EN
      r_bcol            <= '0;
      r_brow            <= '0;
`endif
    end else begin
      r_req_d <= io_bus.gray_req;
      r_dc    <= r_kc;
      r_dr    <= r_kr;
      r_dlast <= (r_kc == 2'd2) && (r_kr == 2'd2);
      if (r_req_d) r_win[r_dc][r_dr] <= io_bus.gray_data;

      case (r_state)
        S_IDLE: begin
          if (io_bus.gray_ready) begin
            r_row      <= ADDR_W'(1);
            r_col      <= ADDR_W'(1);
            r_base     <= '0;
            r_row_base <= '0;
            r_kc       <= '0;
            r_kr       <= '0;
`ifdef LBP_BORDER_WRITE_EN
            r_state          <= S_BORDER;
            r_bcol           <= '0;
            r_brow           <= '0;
            io_bus.lbp_valid <= 1'b1;
            io_bus.lbp_addr  <= '0;
            io_bus.lbp_data  <= 8'h00;
`else
            r_state          <= S_LOAD;
            io_bus.gray_req  <= 1'b1;
            io_bus.gray_addr <= '0;
`endif
          end
        end
`ifdef LBP_BORDER_WRITE_EN
        // lbp_addr doubles as the scan counter; lbp_valid flags only the border addresses.
        S_BORDER: begin
          if (io_bus.lbp_addr == LP_LAST_ADDR) begin
            io_bus.lbp_valid <= 1'b0;
            r_state          <= S_LOAD;
            io_bus.gray_req  <= 1'b1;
            io_bus.gray_addr <= '0;
          end else begin
            io_bus.lbp_addr  <= io_bus.lbp_addr + 1'b1;
            io_bus.lbp_valid <= w_bord_n;
            r_bcol           <= w_bcol_n;
            r_brow           <= w_brow_n;
          end
        end
`endif
        S_LOAD, S_COL: begin
          if (io_bus.gray_req) begin
            if (r_kc == 2'd2 && r_kr == 2'd2) begin
              io_bus.gray_req <= 1'b0;
            end else begin
              r_kr             <= w_kr_n;
              r_kc             <= w_kc_n;
              io_bus.gray_addr <= w_next;
            end
          end
          if (r_req_d && r_dlast) begin
            io_bus.lbp_valid <= 1'b1;
            io_bus.lbp_addr  <= r_base + LP_W + 1'b1;
            io_bus.lbp_data  <= w_code;
            r_state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          io_bus.lbp_valid <= 1'b0;
          if (r_col < LP_COL_LAST) begin
            r_col            <= r_col + 1'b1;
            r_base           <= r_base + 1'b1;
            r_state          <= S_COL;
            io_bus.gray_req  <= 1'b1;
            io_bus.gray_addr <= r_base + ADDR_W'(3);
            r_kc             <= 2'd2;
            r_kr             <= 2'd0;
            for (int i = 0; i < 3; i++) begin
              r_win[0][i] <= r_win[1][i];
              r_win[1][i] <= r_win[2][i];
            end
          end else if (r_row < LP_ROW_LAST) begin
            r_row            <= r_row + 1'b1;
            r_col            <= ADDR_W'(1);
            r_row_base       <= r_row_base + LP_W;
            r_base           <= r_row_base + LP_W;
            r_state          <= S_LOAD;
            io_bus.gray_req  <= 1'b1;
            io_bus.gray_addr <= r_row_base + LP_W;
            r_kc             <= '0;
            r_kr             <= '0;
          end else begin
            r_state       <= S_DONE;
            io_bus.finish <= 1'b1;
          end
        end
        S_DONE: begin
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lbp_param.sv
// tb/tb_lbp_param.sv - directed bench for lbp_param on 3x3 (10-bit), 5x3 uniform and 7x5 images
module tb_lbp_param;
`ifdef LBP_BORDER_WRITE_EN
  localparam int BORD = 1;
`else
  localparam int BORD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- instance A: 3x3, 10-bit pixels
  logic rst_a = 1'b1;
  lbp_param_if #(.ADDR_W(4), .PIX_W(10)) if_a ();
  lbp_param #(.IMG_W(3), .IMG_H(3), .PIX_W(10), .ADDR_W(4)) u_a (.clk(clk), .reset(rst_a), .io_bus(if_a));
  logic [9:0] gmem_a [16];
  int wcnt_a = 0, waddr_a = 0, wdata_a = 0, wcyc_a = 0, fcyc_a = -1, freq_a = -1;
  always @(posedge clk) if (if_a.gray_req) if_a.gray_data <= gmem_a[if_a.gray_addr];
  always @(negedge clk) begin
    if (if_a.gray_req && freq_a < 0) freq_a = cyc;
    if (if_a.lbp_valid) begin
      wcnt_a++; waddr_a = int'(if_a.lbp_addr); wdata_a = int'(if_a.lbp_data); wcyc_a = cyc;
    end
    if (if_a.finish && fcyc_a < 0) fcyc_a = cyc;
  end

  // ---------------- instance B: 5x3, uniform 8'h80
  logic rst_b = 1'b1;
  lbp_param_if #(.ADDR_W(4), .PIX_W(8)) if_b ();
  lbp_param #(.IMG_W(5), .IMG_H(3), .PIX_W(8), .ADDR_W(4)) u_b (.clk(clk), .reset(rst_b), .io_bus(if_b));
  int qa_b[$], qd_b[$], qc_b[$];
  always @(posedge clk) if (if_b.gray_req) if_b.gray_data <= 8'h80;
  always @(negedge clk) if (if_b.lbp_valid) begin
    qa_b.push_back(int'(if_b.lbp_addr)); qd_b.push_back(int'(if_b.lbp_data)); qc_b.push_back(cyc);
  end

  // ---------------- instance D: 7x5, 8-bit pattern
  logic rst_d = 1'b1;
  lbp_param_if #(.ADDR_W(6), .PIX_W(8)) if_d ();
  lbp_param #(.IMG_W(7), .IMG_H(5), .PIX_W(8), .ADDR_W(6)) u_d (.clk(clk), .reset(rst_d), .io_bus(if_d));
  logic [7:0] gmem_d [64];
  logic [7:0] res_d [64];
  int wn_d [64];
  int wtot_d = 0, lastw_d = 0, freq_d = -1, fcyc_d = -1;
  always @(posedge clk) if (if_d.gray_req) if_d.gray_data <= gmem_d[if_d.gray_addr];
  always @(negedge clk) begin
    if (if_d.gray_req && freq_d < 0) freq_d = cyc;
    if (if_d.lbp_valid) begin
      res_d[if_d.lbp_addr] = if_d.lbp_data;
      wn_d[if_d.lbp_addr]++;
      wtot_d++;
      lastw_d = cyc;
    end
    if (if_d.finish && fcyc_d < 0) fcyc_d = cyc;
  end

  function automatic int gold_d(input int a);
    int r, c, ctr, code;
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    r = a / 7; c = a % 7; ctr = int'(gmem_d[a]); code = 0;
    for (int k = 0; k < 8; k++)
      if (int'(gmem_d[(r + dr[k]) * 7 + c + dc[k]]) >= ctr) code = code | (1 << k);
    return code;
  endfunction

  typedef struct {
    logic [9:0] px [9];
    int         code;
  } vec_t;
  vec_t tv[$];

  task automatic add_vec(input int tl, t, tr, l, ce, r, bl, b, br, input int code);
    vec_t v;
    v.px[0] = 10'(tl); v.px[1] = 10'(t);  v.px[2] = 10'(tr);
    v.px[3] = 10'(l);  v.px[4] = 10'(ce); v.px[5] = 10'(r);
    v.px[6] = 10'(bl); v.px[7] = 10'(b);  v.px[8] = 10'(br);
    v.code = code;
    tv.push_back(v);
  endtask

  int ea[$], ed[$];
  int bad, wsave;

  initial begin
    add_vec(60, 40, 50, 10, 50, 70, 50, 20, 90, 'hB5);
    add_vec('h1FF, 'h1FF, 'h1FF, 'h1FF, 'h200, 'h200, 'h1FF, 'h1FF, 'h1FF, 'h10);
    add_vec(5, 5, 5, 5, 5, 5, 5, 5, 5, 'hFF);
    add_vec('h3FE, 'h3FE, 0, 1, 'h3FF, 'h3FE, 'h200, 'h3FE, 7, 'h00);
    add_vec(0, 1, 0, 1, 1, 0, 1, 0, 1, 'hAA);
    add_vec('h3FF, 'h0FF, 'h100, 'h200, 'h100, 0, 'h101, 'h080, 'h300, 'hAD);
    for (int a = 0; a < 64; a++) begin
      gmem_d[a] = 8'(((a * 13) % 7) * 40);
      res_d[a]  = 8'hEE;
      wn_d[a]   = 0;
    end
    if_a.gray_ready = 1'b0; if_b.gray_ready = 1'b0; if_d.gray_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req",    int'(if_d.gray_req),  0);
    check("rst_valid",  int'(if_d.lbp_valid), 0);
    check("rst_finish", int'(if_d.finish),    0);
    check("rst_addr",   int'(if_d.gray_addr), 0);
    check("rst_lbp",    int'({if_d.lbp_addr, if_d.lbp_data}), 0);

    // A: single-window vectors
    foreach (tv[i]) begin
      rst_a = 1'b1; if_a.gray_ready = 1'b0;
      for (int k = 0; k < 9; k++) gmem_a[k] = tv[i].px[k];
      repeat (2) @(negedge clk);
      wcnt_a = 0; freq_a = -1; fcyc_a = -1;
      rst_a = 1'b0; if_a.gray_ready = 1'b1;
      for (int k = 0; k < 60 && fcyc_a < 0; k++) @(negedge clk);
      check($sformatf("a%0d_finish", i), int'(if_a.finish), 1);
      check($sformatf("a%0d_wcnt", i), wcnt_a, 1 + 8 * BORD);
      check($sformatf("a%0d_addr", i), waddr_a, 4);
      check($sformatf("a%0d_code", i), wdata_a, tv[i].code);
      check($sformatf("a%0d_lat", i), wcyc_a - freq_a, 10);
      check($sformatf("a%0d_fin_lat", i), fcyc_a - wcyc_a, 1);
      repeat (3) @(negedge clk);
      check($sformatf("a%0d_sticky", i), int'(if_a.finish) * 100 + wcnt_a, 100 + 1 + 8 * BORD);
    end

    // B: uniform 5x3
    for (int a = 0; a < 15; a++)
      if (BORD != 0 && (a < 5 || a >= 10 || a % 5 == 0 || a % 5 == 4)) begin
        ea.push_back(a); ed.push_back(0);
      end
    for (int a = 6; a <= 8; a++) begin ea.push_back(a); ed.push_back('hFF); end
    rst_b = 1'b0; if_b.gray_ready = 1'b1;
    for (int k = 0; k < 200 && !if_b.finish; k++) @(negedge clk);
    check("b_finish", int'(if_b.finish), 1);
    check("b_wcnt", qa_b.size(), ea.size());
    for (int k = 0; k < ea.size() && k < qa_b.size(); k++) begin
      check($sformatf("b_addr%0d", k), qa_b[k], ea[k]);
      check($sformatf("b_data%0d", k), qd_b[k], ed[k]);
    end
    if (qc_b.size() >= 3) begin
      check("b_gap1", qc_b[qc_b.size()-2] - qc_b[qc_b.size()-3], 5);
      check("b_gap2", qc_b[qc_b.size()-1] - qc_b[qc_b.size()-2], 5);
    end

    // D: idle hold, first request, mid-row reset, full run
    rst_d = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_d.gray_req || if_d.lbp_valid || if_d.finish) bad++;
    end
    check("d_idle_quiet", bad, 0);
    if_d.gray_ready = 1'b1;
    @(negedge clk);
    check("d_first_strobe", int'(if_d.gray_req) + int'(if_d.lbp_valid), 1);
    check("d_first_req", int'(if_d.gray_req), 1 - BORD);
    check("d_first_addr", int'(if_d.gray_addr) + int'(if_d.lbp_addr), 0);
    repeat (40) @(negedge clk);
    rst_d = 1'b1;
    @(negedge clk);
    check("d_rst_req",    int'(if_d.gray_req),  0);
    check("d_rst_valid",  int'(if_d.lbp_valid), 0);
    check("d_rst_finish", int'(if_d.finish),    0);
    for (int a = 0; a < 64; a++) wn_d[a] = 0;
    for (int a = 0; a < 35; a++) begin
      int r, c;
      r = a / 7; c = a % 7;
      if (r == 0 || r == 4 || c == 0 || c == 6) res_d[a] = 8'hEE;
    end
    wtot_d = 0; freq_d = -1; fcyc_d = -1;
    @(negedge clk);
    rst_d = 1'b0;
    for (int k = 0; k < 400 && fcyc_d < 0; k++) @(negedge clk);
    check("d_finish", int'(if_d.finish), 1);
    check("d_wtot", wtot_d, 15 + 20 * BORD);
    check("d_interior_cycles", lastw_d - freq_d + 1, 93);
    check("d_fin_lat", fcyc_d - lastw_d, 1);
    for (int a = 0; a < 35; a++) begin
      int r, c;
      r = a / 7; c = a % 7;
      if (r > 0 && r < 4 && c > 0 && c < 6) begin
        check($sformatf("d_wn%0d", a), wn_d[a], 1);
        check($sformatf("d_res%0d", a), int'(res_d[a]), gold_d(a));
      end else begin
        check($sformatf("d_bwn%0d", a), wn_d[a], BORD);
        check($sformatf("d_bres%0d", a), int'(res_d[a]), BORD != 0 ? 0 : 'hEE);
      end
    end
    wsave = wtot_d;
    if_d.gray_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("d_sticky", int'(if_d.finish), 1);
    check("d_no_more_writes", wtot_d, wsave);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
